instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch/issue block that sits in front of the main control decoder.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Presents each instruction and its 6-bit opcode to the decoder and datapath with a valid/ready handshake.
- Consumes the decoder's Jump output and the datapath's branch-taken result to select the next PC.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, level, held until ack
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle
- imem_rdata  in  DATA_W  fetched instruction word
- instr_valid  out  1  instr/opcode/pc_out valid for issue
- instr_ready  in  1  datapath accepts the issued instruction this cycle
- instr  out  DATA_W  held instruction word
- opcode  out  6  instr[31:26], drives the control decoder input
- pc_out  out  ADDR_W  PC of the held instruction
- jump  in  1  decoder Jump for the held instruction
- branch_taken  in  1  Branch AND ALU-zero for the held instruction

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, pc_out=RESET_PC.
- opcode=0 during reset decodes as R-type (RegWrite=1), so the datapath gates all writes with instr_valid.
- FSM states: IDLE, FETCH, HOLD.
- IDLE: lasts one cycle after reset, then goes to FETCH. imem_req=0; any imem_ack in IDLE is ignored, which covers a stale ack from a transaction outstanding at reset.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: capture instr<=imem_rdata and pc_out<=pc, set instr_valid=1 next cycle, go to HOLD.
  - Zero-wait ack (in the same cycle req first rises) is legal.
  - Minimum latency, FETCH entry to instr_valid: 1 cycle.
- HOLD: instr_valid=1; instr and pc_out stay stable until accepted. jump and branch_taken are sampled only when instr_valid & instr_ready.
- Accept: on instr_valid & instr_ready, compute next pc, clear instr_valid next cycle, go to FETCH.
  - Throughput: at best one instruction per 2 cycles. No prefetch, single buffer entry.
- Next-PC selection (priority high to low):
  - jump: {pc4[31:28], instr[25:0], 2'b00}
  - branch_taken: pc4 + (sign_extend(instr[15:0]) << 2)
  - else: pc4
  - pc4 = pc_out + 4.
- Arithmetic: all arithmetic is modulo 2^ADDR_W. pc 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- jump and branch_taken both high: jump wins.
- imem_ack in HOLD or IDLE: ignored, no state change, instruction not overwritten.
- rst at any state, including mid-FETCH or in HOLD with instr_ready=1 in the same cycle: reset wins and the accept is discarded.
- imem_addr[1:0] is always 00: targets are word-aligned by construction, and RESET_PC must be word-aligned.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE/FETCH/HOLD)
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010, OP_ADDI=001000
  - PC_STEP=4
- The control decoder and benches use the same package.
- One sub-module: next_pc_calc, purely combinational (pc_out, instr, jump, branch_taken -> next_pc). Target arithmetic is unit-tested in isolation.

Test Plan:
- Reset and zero-wait fetch: rst 2 cycles, imem_ack tied high, instr_ready=1, no jump/branch -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 2nd cycle; opcode equals rdata[31:26].
- Wait states: ack delayed 3 cycles -> imem_req held, imem_addr constant 0x10 throughout; instr_valid rises the cycle after ack.
- Backpressure: instr_ready=0 for 5 cycles with stray ack pulses -> instr, pc_out, instr_valid unchanged; no new imem_req until accept.
- Branch: pc_out=0x20, instr=BEQ imm=0xFFFE, branch_taken=1 on accept -> next imem_addr=0x1C. With imm=0x0003 -> 0x30.
- Jump vs branch: pc_out=0x8000_0040, instr=J target 0x0000100, jump=1 and branch_taken=1 -> imem_addr=0x8000_0400.
- Wrap and reset mid-op: RESET_PC=0xFFFF_FFFC, sequential accept -> imem_addr=0x0. Then rst during FETCH with ack arriving in IDLE -> ack ignored, fetch restarts at RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit, the control decoder
// and their benches: fetch FSM states, opcode encodings and PC step size.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int unsigned PC_STEP = 4;

  // Major opcode field of a 32-bit instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for the held instruction: jump beats branch beats
// sequential. Only the low 26 instruction bits matter here (the jump index,
// whose low half is also the branch immediate). Arithmetic wraps at ADDR_W.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_out,
  input  logic [25:0]       instr,
  input  logic              jump,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;

  // Build all three candidate targets and pick one by priority.
  always_comb begin
    pc4           = pc_out + ADDR_W'(PC_STEP);
    jump_target   = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
    branch_offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    branch_target = pc4 + branch_offset;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue unit: fetches one word at a time over a req/ack
// memory handshake, holds it for the decoder/datapath until accepted, then
// steers the PC using the decoder's jump and the datapath's branch result.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              jump,
  input  logic              branch_taken
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .pc_out      (pc_out_q),
    .instr       (instr_q[25:0]),
    .jump        (jump),
    .branch_taken(branch_taken),
    .next_pc     (next_pc)
  );

  // Next-state logic: acks only count in FETCH, accepts only in HOLD; the
  // request and valid flags are registered copies of the next state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (instr_valid_q && instr_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == HOLD);
  end

  // Fetch FSM registers; reset takes priority over any ack or accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_out_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = opcode_of(instr_q[31:0]);
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: three instances with different reset PCs share
// one stimulus stream; a transaction-level model predicts every output.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int NDUT = 3;
  localparam logic [31:0] RPC [NDUT] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h8000_0040};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;

  logic        imem_req_o    [NDUT];
  logic [31:0] imem_addr_o   [NDUT];
  logic        instr_valid_o [NDUT];
  logic [31:0] instr_o       [NDUT];
  logic [5:0]  opcode_o      [NDUT];
  logic [31:0] pc_out_o      [NDUT];

  int vectors = 0;
  int miscompares = 0;

  // Model state: is an instruction held, is this the post-reset idle cycle,
  // where the next fetch goes, and what the held instruction/PC are.
  bit          m_live = 1'b0;
  bit          m_have [NDUT];
  bit          m_idle [NDUT];
  logic [31:0] m_addr [NDUT];
  logic [31:0] m_instr[NDUT];
  logic [31:0] m_pc   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instr_fetch_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(RPC[g])
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req_o[g]),
      .imem_addr   (imem_addr_o[g]),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid_o[g]),
      .instr_ready (instr_ready),
      .instr       (instr_o[g]),
      .opcode      (opcode_o[g]),
      .pc_out      (pc_out_o[g]),
      .jump        (jump),
      .branch_taken(branch_taken)
    );
  end

  // Target of the held instruction, straight from the ISA rules.
  function automatic logic [31:0] spec_next(input logic [31:0] pc, input logic [31:0] ins,
                                            input bit j, input bit b);
    logic [31:0] pc4;
    int off;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b) begin
      off = int'($signed(ins[15:0]));
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Compare every instance against the model for the current cycle.
  task automatic checkCycle();
    if (!m_live) return;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("d%0d.imem_req", k), 32'(imem_req_o[k]),
                  32'(!m_have[k] && !m_idle[k]));
      if (!m_have[k] && !m_idle[k])
        checkOutput($sformatf("d%0d.imem_addr", k), imem_addr_o[k], m_addr[k]);
      checkOutput($sformatf("d%0d.instr_valid", k), 32'(instr_valid_o[k]), 32'(m_have[k]));
      if (m_have[k]) begin
        checkOutput($sformatf("d%0d.instr", k), instr_o[k], m_instr[k]);
        checkOutput($sformatf("d%0d.opcode", k), 32'(opcode_o[k]), 32'(m_instr[k][31:26]));
        checkOutput($sformatf("d%0d.pc_out", k), pc_out_o[k], m_pc[k]);
      end
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_have[k]  = 1'b0;
        m_idle[k]  = 1'b1;
        m_addr[k]  = RPC[k];
        m_instr[k] = '0;
        m_pc[k]    = RPC[k];
      end else if (m_live) begin
        if (m_idle[k]) begin
          m_idle[k] = 1'b0;
        end else if (!m_have[k]) begin
          if (imem_ack) begin
            m_have[k]  = 1'b1;
            m_instr[k] = imem_rdata;
            m_pc[k]    = m_addr[k];
          end
        end else if (instr_ready) begin
          m_addr[k] = spec_next(m_pc[k], m_instr[k], jump, branch_taken);
          m_have[k] = 1'b0;
        end
      end
    end
    if (rst) m_live = 1'b1;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, step model, cross edge.
  task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                               input logic rdy, input logic j, input logic b);
    rst          = r;
    imem_ack     = a;
    imem_rdata   = d;
    instr_ready  = rdy;
    jump         = j;
    branch_taken = b;
    @(negedge clk);
    checkCycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word (FETCH cycle with ack) then accept it with jump/branch.
  task automatic fetchAccept(input logic [31:0] d, input logic j, input logic b);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, $urandom, 1'b1, j, b);
  endtask

  initial begin
    logic [31:0] dv;
    logic [31:0] held;
    logic [31:0] beq_neg;
    logic [31:0] beq_pos;
    logic [31:0] j_instr;
    beq_neg = {OP_BEQ, 5'd3, 5'd4, 16'hFFFE};
    beq_pos = {OP_BEQ, 5'd3, 5'd4, 16'h0003};
    j_instr = {OP_J, 26'h000_0100};

    // Reset for two cycles with a stale ack asserted.
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rst.d%0d.valid", k), 32'(instr_valid_o[k]), 32'd0);
      checkOutput($sformatf("rst.d%0d.req", k), 32'(imem_req_o[k]), 32'd0);
      checkOutput($sformatf("rst.d%0d.instr", k), instr_o[k], 32'd0);
      checkOutput($sformatf("rst.d%0d.pc_out", k), pc_out_o[k], RPC[k]);
    end

    // Idle cycle (ack ignored), then zero-wait fetches with ready high.
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("zw.req", 32'(imem_req_o[0]), 32'd1);
      checkOutput("zw.addr", imem_addr_o[0], 32'(4 * i));
      checkOutput("zw.wrap_addr", imem_addr_o[1], RPC[1] + 32'(4 * i));
      dv = $urandom;
      applyStimulus(1'b0, 1'b1, dv, 1'b1, 1'b0, 1'b0);
      checkOutput("zw.valid", 32'(instr_valid_o[0]), 32'd1);
      checkOutput("zw.opcode", 32'(opcode_o[0]), 32'(dv[31:26]));
      applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      checkOutput("zw.valid_low", 32'(instr_valid_o[0]), 32'd0);
    end
    fetchAccept($urandom, 1'b0, 1'b0);

    // Wait states: ack delayed three cycles at address 0x10.
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
      checkOutput("ws.req", 32'(imem_req_o[0]), 32'd1);
      checkOutput("ws.addr", imem_addr_o[0], 32'h10);
    end
    held = $urandom;
    applyStimulus(1'b0, 1'b1, held, 1'b0, 1'b0, 1'b0);
    checkOutput("ws.valid", 32'(instr_valid_o[0]), 32'd1);
    checkOutput("ws.pc_out", pc_out_o[0], 32'h10);

    // Backpressure with stray acks and ignored jump/branch.
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b0, 1'(b % 2 == 0), $urandom, 1'b0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkOutput("bp.instr", instr_o[0], held);
      checkOutput("bp.pc_out", pc_out_o[0], 32'h10);
      checkOutput("bp.req", 32'(imem_req_o[0]), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
    checkOutput("bp.next_addr", imem_addr_o[0], 32'h14);

    // Branches from 0x20, backwards then forwards.
    fetchAccept($urandom, 1'b0, 1'b0);
    fetchAccept($urandom, 1'b0, 1'b0);
    fetchAccept($urandom, 1'b0, 1'b0);
    checkOutput("br.start", imem_addr_o[0], 32'h20);
    fetchAccept(beq_neg, 1'b0, 1'b1);
    checkOutput("br.neg", imem_addr_o[0], 32'h1C);
    fetchAccept($urandom, 1'b0, 1'b0);
    fetchAccept(beq_pos, 1'b0, 1'b1);
    checkOutput("br.pos", imem_addr_o[0], 32'h30);

    // Reset mid-fetch with an ack during reset and in the idle cycle.
    applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rmid.d%0d.valid", k), 32'(instr_valid_o[k]), 32'd0);
      checkOutput($sformatf("rmid.d%0d.addr", k), imem_addr_o[k], RPC[k]);
    end

    // Jump and branch together: jump wins.
    fetchAccept(j_instr, 1'b1, 1'b1);
    checkOutput("jmp.d2", imem_addr_o[2], 32'h8000_0400);
    checkOutput("jmp.d0", imem_addr_o[0], 32'h0000_0400);

    // Reset while holding with ready high: accept discarded.
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rhold.d%0d.valid", k), 32'(instr_valid_o[k]), 32'd0);
      checkOutput($sformatf("rhold.d%0d.pc_out", k), pc_out_o[k], RPC[k]);
    end
    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    checkOutput("rhold.addr", imem_addr_o[0], RPC[0]);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
